aprsc_pred: RTL and testbench
=============================

// Module: aprsc_pred
// PURPOSE
//  G.726 adaptive predictor and reconstructed-signal calculator (APRSC) for one ADPCM channel.
//  Single multiplier: FMULT is time-shared over 8 cycles, giving sez (B-part) and se (full estimate).
//  An update step forms sr = se + dq and shifts the float delay lines (DQ1..DQ6, SR1..SR2).
//  Sits between the coefficient-update block (supplies a1,a2,b1..b6) and the quantizer/decoder.
// PARAMETERS
//  none; all word widths fixed by G.726 (16 TC coeffs, 16 SM dq, 11-bit float delay words)
// PORTS
//  clk          in   1   rising-edge clock (sole clock)
//  reset        in   1   asynchronous, active-low reset
//  scan_in0..4  in   1   DFT scan inputs (chains stitched at synthesis; unused in RTL)
//  scan_enable  in   1   DFT scan shift enable (unused in RTL)
//  test_mode    in   1   DFT test mode (unused in RTL)
//  scan_out0..4 out  1   DFT scan outputs; tied 0 in RTL
//  pred_start   in   1   pulse: begin predictor evaluation
//  a1,a2        in   16  pole coeffs, TC; hold stable while busy
//  b1..b6       in   16  zero coeffs, TC; hold stable while busy
//  upd          in   1   pulse: apply dq, compute sr, shift delay lines
//  dq           in   16  quantized difference, sign-magnitude (bit15 sign)
//  busy         out  1   evaluation in progress
//  pred_done    out  1   one-cycle pulse: se/sez updated
//  se, sez      out  15  signal estimate / zero-part estimate, TC
//  sr           out  16  reconstructed signal, TC, registered
// BEHAVIOUR
//  Reset (async, reset=0): se=sez=sr=0, busy=pred_done=0, DQ1..6=SR1..2=11'd32 (float zero).
//  FMULT(An 16TC, Xn 11FL): mag=|An|>>2 (13b); exp=bitlen(mag); mant=mag?(mag<<6)>>exp:32;
//   wmant=(Xmant*mant+48)>>4; wexp=Xexp+exp; wmag=wexp<=26?(wmant<<7)>>(26-wexp):((wmant<<7)<<(wexp-26))&16'h7FFF;
//   W = (Xs^As) ? -wmag : wmag (16-bit two's complement wrap).
//  Eval: pred_start accepted only when idle and upd=0; busy=1 for exactly 8 cycles.
//   Cycle order b1*DQ1..b6*DQ6, then a2*SR2, a1*SR1; 16-bit wrap accumulation.
//   After b6: sezi latched; after a1: sei. Next cycle: sez=sezi>>>1, se=sei>>>1, pred_done=1, busy=0.
//  Update (idle only; upd wins over simultaneous pred_start, which is dropped): single cycle.
//   sr <= sext16(se) + (dq[15] ? -dq[14:0] : dq[14:0]) (mod 2^16);
//   DQ6..DQ2 <= DQ5..DQ1; DQ1 <= FLOATA(dq); SR2 <= SR1; SR1 <= FLOATB(new sr).
//  FLOAT: mag (15b), exp=bitlen(mag) 0..15, mant=mag?(mag<<6)>>exp:32, word={s,exp[3:0],mant[5:0]}.
//  pred_start/upd during busy: ignored, no state change. Reset mid-evaluation aborts; no pred_done.
//  se/sez/sr hold between updates.
// CONFIGURATION
//  APRSC_CLEAR_EN defined: extra input clr (1b). When idle and clr=1 (priority over upd/pred_start),
//   sync reload DQ1..6/SR1..2=32, se=sez=sr=0. While busy, clr is ignored.
//  Undefined: no clr port; delay lines cleared only by reset.
// STRUCTURE
//  aprsc_pkg:
//   - float word typedef (struct s/exp/mant)
//   - FL_ZERO=11'd32, N_PROD=8
//   - floata/floatb functions
//  Sub-module aprsc_fmult (combinational FMULT), one instance.
//  Top holds the 3-bit step counter, accumulator and delay-line registers.
// TESTING
//  reset, all coeffs 0, pred_start -> busy 8 cycles, pred_done, se=0, sez=0.
//  From reset, upd dq=16'h0040 -> sr=16'h0040; DQ1=SR1=11'h1E0.
//  Then b1=16'h4000, others 0, pred_start -> sez=15'h0043, se=15'h0043.
//  From reset, upd dq=16'h8040 -> sr=16'hFFC0; DQ1=SR1=11'h5E0.
//  pred_start held during busy, or upd+pred_start together -> one pred_done per accepted start; upd prioritized.
//  reset asserted mid-evaluation -> busy=0, outputs 0, delay lines 11'd32, no pred_done.

Source files
------------

// File: rtl/aprsc_pkg.sv
// Shared types and helpers for the G.726 adaptive predictor (APRSC).
// Optional synchronous clear of the delay lines is enabled with APRSC_CLEAR_EN.
package aprsc_pkg;

   // 11-bit G.726 float word: sign, 4-bit exponent, 6-bit normalised mantissa
   typedef struct packed {
      logic       s;
      logic [3:0] exp;
      logic [5:0] mant;
   } fl_word_t;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } state_e;

   localparam fl_word_t   FL_ZERO     = '{s: 1'b0, exp: 4'd0, mant: 6'd32};
   localparam int         N_PROD      = 8;
   localparam logic [2:0] LAST_B_STEP = 3'd5;
   localparam logic [2:0] LAST_STEP   = 3'(N_PROD - 1);

   function automatic logic [3:0] bitlen15(input logic [14:0] mag);
      logic [3:0] n;
      n = 4'd0;
      for (int i = 0; i < 15; i++) begin
         if (mag[i]) n = 4'(i + 1);
      end
      return n;
   endfunction

   // A zero magnitude still carries mantissa 32 so that float zero is 11'd32
   function automatic logic [5:0] fl_mant(input logic [14:0] mag, input logic [3:0] exp);
      if (mag == 15'd0) return 6'd32;
      return 6'({mag, 6'b0} >> exp);
   endfunction

   function automatic fl_word_t fl_pack(input logic s, input logic [14:0] mag);
      fl_word_t w;
      w.s    = s;
      w.exp  = bitlen15(mag);
      w.mant = fl_mant(mag, w.exp);
      return w;
   endfunction

   // dq arrives sign-magnitude
   function automatic fl_word_t floata(input logic [15:0] dq);
      return fl_pack(dq[15], dq[14:0]);
   endfunction

   // sr arrives two's complement; -32768 folds to magnitude 0
   function automatic fl_word_t floatb(input logic [15:0] sr);
      return fl_pack(sr[15], 15'(sr[15] ? 16'(-sr) : sr));
   endfunction

endpackage

// File: rtl/aprsc_if.sv
// Request/result bundle between the coefficient-update/quantizer side and the APRSC.
// Carries the optional clr request when APRSC_CLEAR_EN is defined.
interface aprsc_if;
   // pred_start and upd are one-cycle requests, honoured only in a cycle where
   // busy=0 (upd wins a tie); coefficients must stay stable while busy=1, and
   // pred_done pulses for one cycle when se/sez carry the new estimate.
   logic        pred_start;
   logic [15:0] a1, a2;
   logic [15:0] b1, b2, b3, b4, b5, b6;
   logic        upd;
   logic [15:0] dq;
`ifdef APRSC_CLEAR_EN
   logic        clr;
`endif
   logic        busy;
   logic        pred_done;
   logic [14:0] se, sez;
   logic [15:0] sr;

   modport master (
`ifdef APRSC_CLEAR_EN
      output clr,
`endif
      output pred_start, a1, a2, b1, b2, b3, b4, b5, b6, upd, dq,
      input  busy, pred_done, se, sez, sr
   );

   modport slave (
`ifdef APRSC_CLEAR_EN
      input  clr,
`endif
      input  pred_start, a1, a2, b1, b2, b3, b4, b5, b6, upd, dq,
      output busy, pred_done, se, sez, sr
   );
endinterface

// File: rtl/aprsc_fmult.sv
// Combinational G.726 FMULT: 16-bit TC coefficient times 11-bit float delay word.
module aprsc_fmult
   import aprsc_pkg::*;
(
   input  logic [15:0] an,
   input  fl_word_t    xn,
   output logic [15:0] wn
);

   logic [15:0] an_abs;
   logic [12:0] an_mag;
   logic [3:0]  an_exp;
   logic [5:0]  an_mant;
   logic [12:0] prod;
   logic [7:0]  wmant;
   logic [4:0]  wexp;
   logic [16:0] wide;
   logic [14:0] wmag;

   always_comb begin
      an_abs  = an[15] ? 16'(-an) : an;
      // |-32768|>>2 does not fit 13 bits and wraps to zero, as in the reference
      an_mag  = 13'(an_abs >> 2);
      an_exp  = bitlen15({2'b00, an_mag});
      an_mant = fl_mant({2'b00, an_mag}, an_exp);

      prod  = {7'b0, xn.mant} * {7'b0, an_mant} + 13'd48;
      wmant = 8'(prod >> 4);
      wexp  = {1'b0, xn.exp} + {1'b0, an_exp};
      wide  = {2'b00, wmant, 7'b0};

      if (wexp <= 5'd26) begin
         wmag = 15'(wide >> (5'd26 - wexp));
      end else begin
         wmag = 15'(wide << (wexp - 5'd26));
      end

      wn = (xn.s ^ an[15]) ? 16'(-{1'b0, wmag}) : {1'b0, wmag};
   end

endmodule

// File: rtl/aprsc_pred.sv
// G.726 adaptive predictor / reconstructed-signal calculator for one ADPCM channel.
// Define APRSC_CLEAR_EN to add the synchronous clr request on the interface.
module aprsc_pred
   import aprsc_pkg::*;
(
   input  logic    clk,
   input  logic    reset,
   input  logic    scan_in0,
   input  logic    scan_in1,
   input  logic    scan_in2,
   input  logic    scan_in3,
   input  logic    scan_in4,
   input  logic    scan_enable,
   input  logic    test_mode,
   output logic    scan_out0,
   output logic    scan_out1,
   output logic    scan_out2,
   output logic    scan_out3,
   output logic    scan_out4,
   aprsc_if.slave  bus
);

   state_e      state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [15:0] acc_q, acc_d;
   logic [14:0] sezi_q, sezi_d;
   logic [14:0] se_q, se_d;
   logic [14:0] sez_q, sez_d;
   logic [15:0] sr_q, sr_d;
   logic        pred_done_q, pred_done_d;
   fl_word_t    dq_line_q [6];
   fl_word_t    dq_line_d [6];
   fl_word_t    sr_line_q [2];
   fl_word_t    sr_line_d [2];

   logic [15:0] coef_vec [8];
   fl_word_t    x_vec [8];
   logic [15:0] mul_coef;
   fl_word_t    mul_x;
   logic [15:0] prod_w;
   logic [15:0] acc_sum;
   logic [15:0] dq_tc;
   logic [15:0] sr_new;
   logic        clr_req;
   logic        unused_dft;

   assign unused_dft = ^{scan_in0, scan_in1, scan_in2, scan_in3, scan_in4,
                         scan_enable, test_mode};
   assign scan_out0 = 1'b0;
   assign scan_out1 = 1'b0;
   assign scan_out2 = 1'b0;
   assign scan_out3 = 1'b0;
   assign scan_out4 = 1'b0;

`ifdef APRSC_CLEAR_EN
   assign clr_req = bus.clr;
`else
   assign clr_req = 1'b0;
`endif

   // Step order b1..b6 then a2, a1 so the zero-part sum is complete after step 5
   always_comb begin
      coef_vec = '{bus.b1, bus.b2, bus.b3, bus.b4, bus.b5, bus.b6, bus.a2, bus.a1};
      x_vec    = '{dq_line_q[0], dq_line_q[1], dq_line_q[2], dq_line_q[3],
                   dq_line_q[4], dq_line_q[5], sr_line_q[1], sr_line_q[0]};
      mul_coef = coef_vec[step_q];
      mul_x    = x_vec[step_q];
   end

   aprsc_fmult u_fmult (
      .an (mul_coef),
      .xn (mul_x),
      .wn (prod_w)
   );

   assign acc_sum = acc_q + prod_w;

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      acc_d       = acc_q;
      sezi_d      = sezi_q;
      se_d        = se_q;
      sez_d       = sez_q;
      sr_d        = sr_q;
      pred_done_d = 1'b0;
      dq_line_d   = dq_line_q;
      sr_line_d   = sr_line_q;

      dq_tc  = bus.dq[15] ? 16'(-{1'b0, bus.dq[14:0]}) : {1'b0, bus.dq[14:0]};
      sr_new = {se_q[14], se_q} + dq_tc;

      case (state_q)
         ST_IDLE: begin
            if (clr_req) begin
               se_d  = 15'd0;
               sez_d = 15'd0;
               sr_d  = 16'd0;
               for (int i = 0; i < 6; i++) dq_line_d[i] = FL_ZERO;
               for (int i = 0; i < 2; i++) sr_line_d[i] = FL_ZERO;
            end else if (bus.upd) begin
               sr_d = sr_new;
               for (int i = 5; i > 0; i--) dq_line_d[i] = dq_line_q[i-1];
               dq_line_d[0] = floata(bus.dq);
               sr_line_d[1] = sr_line_q[0];
               sr_line_d[0] = floatb(sr_new);
            end else if (bus.pred_start) begin
               state_d = ST_BUSY;
               step_d  = 3'd0;
               acc_d   = 16'd0;
            end
         end
         ST_BUSY: begin
            acc_d  = acc_sum;
            step_d = step_q + 3'd1;
            if (step_q == LAST_B_STEP) sezi_d = acc_sum[15:1];
            if (step_q == LAST_STEP) begin
               se_d        = acc_sum[15:1];
               sez_d       = sezi_q;
               pred_done_d = 1'b1;
               step_d      = 3'd0;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         step_q      <= 3'd0;
         acc_q       <= 16'd0;
         sezi_q      <= 15'd0;
         se_q        <= 15'd0;
         sez_q       <= 15'd0;
         sr_q        <= 16'd0;
         pred_done_q <= 1'b0;
         for (int i = 0; i < 6; i++) dq_line_q[i] <= FL_ZERO;
         for (int i = 0; i < 2; i++) sr_line_q[i] <= FL_ZERO;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         acc_q       <= acc_d;
         sezi_q      <= sezi_d;
         se_q        <= se_d;
         sez_q       <= sez_d;
         sr_q        <= sr_d;
         pred_done_q <= pred_done_d;
         dq_line_q   <= dq_line_d;
         sr_line_q   <= sr_line_d;
      end
   end

   assign bus.busy      = (state_q == ST_BUSY);
   assign bus.pred_done = pred_done_q;
   assign bus.se        = se_q;
   assign bus.sez       = sez_q;
   assign bus.sr        = sr_q;

endmodule

// File: tb/tb_aprsc_pred.sv
// Bench for aprsc_pred: directed G.726 vectors plus randomized update/evaluate sequences
// checked against an integer model of the predictor arithmetic.
module tb_aprsc_pred;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic scan_in0, scan_in1, scan_in2, scan_in3, scan_in4, scan_enable, test_mode;
   logic scan_out0, scan_out1, scan_out2, scan_out3, scan_out4;

   always #5 clk = ~clk;

   aprsc_if bus();

   aprsc_pred dut (
      .clk         (clk),
      .reset       (reset),
      .scan_in0    (scan_in0),
      .scan_in1    (scan_in1),
      .scan_in2    (scan_in2),
      .scan_in3    (scan_in3),
      .scan_in4    (scan_in4),
      .scan_enable (scan_enable),
      .test_mode   (test_mode),
      .scan_out0   (scan_out0),
      .scan_out1   (scan_out1),
      .scan_out2   (scan_out2),
      .scan_out3   (scan_out3),
      .scan_out4   (scan_out4),
      .bus         (bus)
   );

   int tests_run = 0;
   int tests_failed = 0;

   int c_a1, c_a2;
   int c_b [6];
   int m_dq [6];
   int m_sr [2];
   int m_se, m_sez, m_srout;
   logic [29:0] exp_q [$];

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      tests_run++;
      if (got !== want) begin
         tests_failed++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int bitlen(input int m);
      int n;
      n = 0;
      while (m > 0) begin
         n++;
         m = m >> 1;
      end
      return n;
   endfunction

   function automatic int fl_encode(input int s, input int mag);
      int e, mt;
      e  = bitlen(mag);
      mt = (mag == 0) ? 32 : ((mag << 6) >> e);
      return (s << 10) | (e << 6) | mt;
   endfunction

   function automatic int m_fmult(input int an, input int xn);
      int an_s, amag, aexp, amant, xs, xexp, xmant, wmant, wexp, wmag;
      an_s  = (an >> 15) & 1;
      amag  = an_s ? (65536 - an) : an;
      amag  = (amag >> 2) & 8191;
      aexp  = bitlen(amag);
      amant = (amag == 0) ? 32 : ((amag << 6) >> aexp);
      xs    = (xn >> 10) & 1;
      xexp  = (xn >> 6) & 15;
      xmant = xn & 63;
      wmant = (xmant * amant + 48) >> 4;
      wexp  = xexp + aexp;
      if (wexp <= 26) wmag = (wmant << 7) >> (26 - wexp);
      else            wmag = ((wmant << 7) << (wexp - 26)) & 32767;
      return (xs ^ an_s) ? ((65536 - wmag) & 65535) : wmag;
   endfunction

   function automatic void model_pred(output int se_o, output int sez_o);
      int acc;
      acc = 0;
      for (int i = 0; i < 6; i++) acc = (acc + m_fmult(c_b[i], m_dq[i])) & 65535;
      sez_o = (acc >> 1) & 32767;
      acc = (acc + m_fmult(c_a2, m_sr[1])) & 65535;
      acc = (acc + m_fmult(c_a1, m_sr[0])) & 65535;
      se_o = (acc >> 1) & 32767;
   endfunction

   function automatic void model_upd(input int dqv);
      int se_s, dqs, s, mag;
      se_s = (m_se >= 16384) ? (m_se - 32768) : m_se;
      dqs  = ((dqv >> 15) & 1) ? -(dqv & 32767) : (dqv & 32767);
      m_srout = (se_s + dqs) & 65535;
      for (int i = 5; i > 0; i--) m_dq[i] = m_dq[i-1];
      m_dq[0] = fl_encode((dqv >> 15) & 1, dqv & 32767);
      m_sr[1] = m_sr[0];
      s   = (m_srout >> 15) & 1;
      mag = s ? ((65536 - m_srout) & 32767) : (m_srout & 32767);
      m_sr[0] = fl_encode(s, mag);
   endfunction

   function automatic void model_clear();
      for (int i = 0; i < 6; i++) m_dq[i] = 32;
      m_sr[0] = 32;
      m_sr[1] = 32;
      m_se = 0;
      m_sez = 0;
      m_srout = 0;
   endfunction

   // ---------------- drivers ----------------
   task automatic drive_coeffs();
      bus.a1 = 16'(c_a1);
      bus.a2 = 16'(c_a2);
      bus.b1 = 16'(c_b[0]);
      bus.b2 = 16'(c_b[1]);
      bus.b3 = 16'(c_b[2]);
      bus.b4 = 16'(c_b[3]);
      bus.b5 = 16'(c_b[4]);
      bus.b6 = 16'(c_b[5]);
   endtask

   function automatic int rand_coef();
      int r;
      r = int'($urandom_range(0, 9));
      if (r == 0) return 32768;
      if (r == 1) return 32767;
      return int'($urandom_range(0, 65535));
   endfunction

   task automatic apply_reset();
      reset = 1'b0;
      bus.pred_start = 1'b0;
      bus.upd = 1'b0;
      bus.dq = 16'd0;
      repeat (2) @(negedge clk);
      model_clear();
      exp_q.delete();
      check("rst_busy", 32'(bus.busy), 0);
      check("rst_pred_done", 32'(bus.pred_done), 0);
      check("rst_se", 32'(bus.se), 0);
      check("rst_sez", 32'(bus.sez), 0);
      check("rst_sr", 32'(bus.sr), 0);
      reset = 1'b1;
      @(negedge clk);
   endtask

   task automatic do_upd(input int dqv);
      bus.upd = 1'b1;
      bus.dq  = 16'(dqv);
      @(negedge clk);
      bus.upd = 1'b0;
      model_upd(dqv);
      check("upd_sr", 32'(bus.sr), 32'(m_srout));
      check("upd_se_hold", 32'(bus.se), 32'(m_se));
   endtask

   task automatic do_pred(input bit hold, input bit poke_upd);
      int se_e, sez_e, busy_cnt, cyc, extra;
      bit done;
      logic [29:0] e;
      model_pred(se_e, sez_e);
      exp_q.push_back({15'(se_e), 15'(sez_e)});
      bus.pred_start = 1'b1;
      busy_cnt = 0;
      done = 1'b0;
      cyc = 0;
      while (!done && cyc < 20) begin
         @(negedge clk);
         cyc++;
         if (!hold) bus.pred_start = 1'b0;
         if (poke_upd) begin
            bus.upd = (cyc == 3);
            bus.dq  = 16'($urandom_range(0, 65535));
         end
         if (bus.busy) busy_cnt++;
         if (bus.pred_done) begin
            done = 1'b1;
            bus.pred_start = 1'b0;
         end
      end
      bus.pred_start = 1'b0;
      bus.upd = 1'b0;
      check("pred_done_seen", 32'(done), 1);
      check("busy_cycles", 32'(busy_cnt), 8);
      if (done) begin
         e = exp_q.pop_front();
         check("se", 32'(bus.se), 32'(e[29:15]));
         check("sez", 32'(bus.sez), 32'(e[14:0]));
         m_se  = se_e;
         m_sez = sez_e;
      end else begin
         exp_q.delete();
      end
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.pred_done || bus.busy) extra++;
      end
      check("no_extra_eval", 32'(extra), 0);
      check("sr_hold", 32'(bus.sr), 32'(m_srout));
   endtask

   initial begin
      int extra;
      scan_in0 = 1'b0; scan_in1 = 1'b0; scan_in2 = 1'b0; scan_in3 = 1'b0; scan_in4 = 1'b0;
      scan_enable = 1'b0;
      test_mode = 1'b0;
`ifdef APRSC_CLEAR_EN
      bus.clr = 1'b0;
`endif
      c_a1 = 0; c_a2 = 0;
      for (int i = 0; i < 6; i++) c_b[i] = 0;
      drive_coeffs();

      // zero coefficients give zero estimates
      apply_reset();
      check("rst_dq1", 32'(dut.dq_line_q[0]), 32'h20);
      check("rst_sr2", 32'(dut.sr_line_q[1]), 32'h20);
      do_pred(1'b0, 1'b0);
      check("zero_se", 32'(bus.se), 0);

      // positive dq, then b1 only
      apply_reset();
      do_upd(32'h0040);
      check("pos_sr", 32'(bus.sr), 32'h0040);
      check("pos_dq1", 32'(dut.dq_line_q[0]), 32'h1E0);
      check("pos_sr1", 32'(dut.sr_line_q[0]), 32'h1E0);
      c_b[0] = 32'h4000;
      drive_coeffs();
      do_pred(1'b0, 1'b0);
      check("b1_sez", 32'(bus.sez), 32'h43);
      check("b1_se", 32'(bus.se), 32'h43);

      // reset in the middle of an evaluation
      bus.pred_start = 1'b1;
      @(negedge clk);
      bus.pred_start = 1'b0;
      repeat (3) @(negedge clk);
      check("mid_busy", 32'(bus.busy), 1);
      #2 reset = 1'b0;
      #1;
      model_clear();
      check("abort_busy", 32'(bus.busy), 0);
      check("abort_se", 32'(bus.se), 0);
      check("abort_sez", 32'(bus.sez), 0);
      check("abort_sr", 32'(bus.sr), 0);
      check("abort_dq1", 32'(dut.dq_line_q[0]), 32'h20);
      check("abort_sr1", 32'(dut.sr_line_q[0]), 32'h20);
      @(negedge clk);
      reset = 1'b1;
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.pred_done || bus.busy) extra++;
      end
      check("abort_no_done", 32'(extra), 0);

      // negative dq
      apply_reset();
      c_b[0] = 0;
      drive_coeffs();
      do_upd(32'h8040);
      check("neg_sr", 32'(bus.sr), 32'hFFC0);
      check("neg_dq1", 32'(dut.dq_line_q[0]), 32'h5E0);
      check("neg_sr1", 32'(dut.sr_line_q[0]), 32'h5E0);

      // upd and pred_start together: upd applied, start dropped
      bus.upd = 1'b1;
      bus.pred_start = 1'b1;
      bus.dq = 16'h0123;
      @(negedge clk);
      bus.upd = 1'b0;
      bus.pred_start = 1'b0;
      model_upd(32'h0123);
      check("tie_sr", 32'(bus.sr), 32'(m_srout));
      extra = 0;
      repeat (12) begin
         @(negedge clk);
         if (bus.pred_done || bus.busy) extra++;
      end
      check("tie_no_eval", 32'(extra), 0);

      // held pred_start and upd during busy both ignored
      c_a1 = rand_coef();
      c_b[1] = rand_coef();
      drive_coeffs();
      do_pred(1'b1, 1'b1);

`ifdef APRSC_CLEAR_EN
      bus.clr = 1'b1;
      bus.upd = 1'b1;
      @(negedge clk);
      bus.clr = 1'b0;
      bus.upd = 1'b0;
      model_clear();
      check("clr_sr", 32'(bus.sr), 0);
      check("clr_se", 32'(bus.se), 0);
      check("clr_dq1", 32'(dut.dq_line_q[0]), 32'h20);
`endif

      // randomized sequences
      for (int it = 0; it < 30; it++) begin
         int n_upd;
         c_a1 = rand_coef();
         c_a2 = rand_coef();
         for (int i = 0; i < 6; i++) c_b[i] = rand_coef();
         drive_coeffs();
         n_upd = int'($urandom_range(1, 3));
         for (int k = 0; k < n_upd; k++) begin
            if ($urandom_range(0, 1) == 0) do_upd(int'($urandom_range(0, 65535)));
            else do_upd(int'($urandom_range(0, 511)) | (int'($urandom_range(0, 1)) << 15));
         end
         do_pred(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
